fpmult_rr_scheduler: RTL and testbench
======================================

// Module: fpmult_rr_scheduler
// PURPOSE
//  Shares one iterative fixed-point multiplier between NREQ requesters.
//  Round-robin arbitration over request ports; one multiply outstanding at a time.
//  Forwards the granted operand pair to the multiplier and routes the product back to the owner.
//  Sits between client blocks (filters, FFT stages) and a single FpmultVRTL instance.
// PARAMETERS
//  n     32  operand/result bit width
//  d     16  fractional bits (passed through to the multiplier; unused internally)
//  NREQ   4  number of requester ports, 2..16
// PORTS
//  clk            in   1         clock
//  reset          in   1         reset, synchronous, active-high
//  req_val        in   NREQ      per-requester request valid
//  req_rdy        out  NREQ      per-requester request ready
//  req_msg        in   NREQ*2n   per-requester {a,b}; port i at [i*2n +: 2n]
//  resp_val       out  NREQ      per-requester response valid
//  resp_rdy       in   NREQ      per-requester response ready
//  resp_msg       out  n         product, shared by all ports; qualified by resp_val
//  mult_recv_val  out  1         to multiplier recv_val
//  mult_recv_rdy  in   1         from multiplier recv_rdy
//  mult_recv_msg  out  2n        to multiplier recv_msg
//  mult_send_val  in   1         from multiplier send_val
//  mult_send_rdy  out  1         to multiplier send_rdy
//  mult_send_msg  in   n         from multiplier send_msg
//  owner          out  clog2(NREQ)  id of port holding the multiplier (debug/perf)
// BEHAVIOUR
//  Reset: state=IDLE, prio_ptr=0, owner=0; req_rdy, resp_val, mult_recv_val, mult_send_rdy all 0.
//  States: IDLE -> WAIT -> IDLE. Transfers occur when val & rdy are both high on a rising edge.
//  IDLE:
//   - grant = first i with req_val[i], searching from prio_ptr upward and wrapping at NREQ-1 -> 0.
//   - If any req_val: mult_recv_val=1, mult_recv_msg=req_msg[grant], req_rdy[grant]=mult_recv_rdy.
//     All other req_rdy bits are 0.
//   - On mult_recv_val & mult_recv_rdy: owner<=grant; state<=WAIT.
//   - No request, or mult_recv_rdy=0: remain in IDLE; grant is recomputed each cycle.
//  WAIT:
//   - req_rdy=0 on all ports, including owner; mult_recv_val=0.
//   - resp_val[owner]=mult_send_val; mult_send_rdy=resp_rdy[owner]; resp_msg=mult_send_msg.
//     Combinational pass-through; no added latency.
//   - On mult_send_val & resp_rdy[owner]: prio_ptr<=(owner==NREQ-1)?0:owner+1; state<=IDLE.
//   - Owner stalls (resp_rdy=0): hold in WAIT indefinitely and keep mult_send_rdy=0.
//  resp_msg is don't-care when no resp_val bit is set; drive mult_send_msg continuously.
//  Latency: request accept to resp_val equals multiplier latency (n+2 cycles for FpmultVRTL).
//  The response handshake cycle returns to IDLE. A new grant fires no earlier than the next cycle,
//   so there is one bubble minimum between jobs.
//  Fairness: every valid requester is served within NREQ jobs. A port that keeps req_val high
//   cannot win twice in a row while another port is valid.
//  A requester may drop req_val before it is granted; it must not drop it while req_rdy is high.
//  A requester asserting req_val in WAIT is not accepted until the job completes.
//  Reset mid-WAIT: return to reset values next cycle. The multiplier shares reset and is cleared too,
//   so the in-flight result is discarded and no resp_val is issued.
//  Illegal state encoding: go to IDLE.
// STRUCTURE
//  Package fpmult_sched_pkg: state enum {IDLE=0, WAIT=1}, and a log2 helper for the owner width.
//  Sub-module fpmult_rr_arb #(NREQ): combinational. Inputs are the req vector and prio_ptr.
//   Outputs are a one-hot grant plus an encoded id. Implemented as a double-width masked priority encoder.
//  Top level holds state, owner and prio_ptr registers, plus the req_msg select mux and the response demux.
// TESTING (bench stub multiplier with programmable latency L; default L=34)
//  1. Single port 2 sends {0x00020000,0x00030000}; stub returns 0x00060000.
//     -> resp_val[2] only; resp_msg=0x00060000; accept-to-resp = L cycles.
//  2. All 4 ports valid continuously, 8 jobs -> grant order 0,1,2,3,0,1,2,3.
//     prio_ptr ends at 0; one IDLE bubble between jobs.
//  3. Ports 1 and 3 valid, prio_ptr=2 -> port 3 served first, then 1.
//     Checks the 3 -> 0 wrap when port 3 is owner.
//  4. Owner port 0 holds resp_rdy=0 for 10 cycles after mult_send_val.
//     -> mult_send_rdy stays 0; resp_val[0] held; req_rdy all 0; completes on resp_rdy=1.
//  5. Assert reset 5 cycles into WAIT -> next cycle all outputs 0, state IDLE.
//     No resp_val in the 50 following cycles when no requests are made.
//  6. Port 1 raises req_val in WAIT while port 0 owns -> port 1 not accepted until port 0 completes.
//     Port 1 is granted on the first IDLE cycle after.

Source files
------------

// File: rtl/fpmult_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package fpmult_sched_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StWait = 1'b1
    } state_e;

    // Width of an id field; never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/fpmult_rr_arb.sv
// Combinational round-robin arbiter: lowest requester at or above prio_ptr wins,
// wrapping through a double-width request vector.
module fpmult_rr_arb
    import fpmult_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdW  = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IdW-1:0]  prio_ptr,
    output logic [NREQ-1:0] grant_oh,
    output logic [IdW-1:0]  grant_id,
    output logic            grant_any
);

    localparam int unsigned W2 = 2 * NREQ;

    logic [W2-1:0] req2;
    logic [W2-1:0] mask;
    logic [W2-1:0] masked;
    int            pos;

    assign req2      = {req, req};
    assign mask      = ~((W2'(1) << prio_ptr) - W2'(1));
    assign masked    = req2 & mask;
    assign grant_any = |req;

    // Upper copy of req supplies the wrapped candidates below prio_ptr.
    always_comb begin
        pos = 0;
        for (int i = W2 - 1; i >= 0; i--) begin
            if (masked[i]) begin
                pos = i;
            end
        end
        if (pos >= int'(NREQ)) begin
            pos = pos - int'(NREQ);
        end
    end

    assign grant_id = IdW'(pos);
    assign grant_oh = grant_any ? (NREQ'(1) << grant_id) : '0;

endmodule

// File: rtl/fpmult_rr_scheduler.sv
// Shares one iterative fixed-point multiplier among NREQ requesters, one job at a time,
// with round-robin arbitration and response routing back to the owning port.
module fpmult_rr_scheduler
    import fpmult_sched_pkg::*;
#(
    parameter int unsigned n    = 32,
    parameter int unsigned d    = 16,
    parameter int unsigned NREQ = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NREQ-1:0]               req_val,
    output logic [NREQ-1:0]               req_rdy,
    input  logic [NREQ*2*n-1:0]           req_msg,
    output logic [NREQ-1:0]               resp_val,
    input  logic [NREQ-1:0]               resp_rdy,
    output logic [n-1:0]                  resp_msg,
    output logic                          mult_recv_val,
    input  logic                          mult_recv_rdy,
    output logic [2*n-1:0]                mult_recv_msg,
    input  logic                          mult_send_val,
    output logic                          mult_send_rdy,
    input  logic [n-1:0]                  mult_send_msg,
    output logic [clog2_min1(NREQ)-1:0]   owner
);

    localparam int unsigned IdW = clog2_min1(NREQ);
    localparam logic [IdW-1:0] LastId = IdW'(NREQ - 1);

    state_e         state_q, state_d;
    logic [IdW-1:0] owner_q, owner_d;
    logic [IdW-1:0] prio_q, prio_d;

    logic [NREQ-1:0] grant_oh;
    logic [IdW-1:0]  grant_id;
    logic            grant_any;

    // Fractional width only matters inside the multiplier.
    logic [31:0] unused_d;
    assign unused_d = d;

    fpmult_rr_arb #(
        .NREQ(NREQ),
        .IdW (IdW)
    ) u_arb (
        .req      (req_val),
        .prio_ptr (prio_q),
        .grant_oh (grant_oh),
        .grant_id (grant_id),
        .grant_any(grant_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        case (state_q)
            StIdle: begin
                if (grant_any && mult_recv_rdy) begin
                    owner_d = grant_id;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mult_send_val && resp_rdy[owner_q]) begin
                    prio_d  = (owner_q == LastId) ? '0 : owner_q + IdW'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_rdy       = '0;
        resp_val      = '0;
        mult_recv_val = 1'b0;
        mult_send_rdy = 1'b0;
        mult_recv_msg = req_msg[32'(grant_id) * (2 * n) +: 2 * n];
        resp_msg      = mult_send_msg;
        case (state_q)
            StIdle: begin
                mult_recv_val = grant_any;
                req_rdy       = grant_oh & {NREQ{mult_recv_rdy}};
            end
            StWait: begin
                resp_val[owner_q] = mult_send_val;
                mult_send_rdy     = resp_rdy[owner_q];
            end
            default: ;
        endcase
    end

    assign owner = owner_q;

endmodule

// File: tb/tb_fpmult_rr_scheduler.sv
// Bench for fpmult_rr_scheduler: stub multiplier with programmable latency and a
// round-robin reference model kept as a plain priority integer.
module tb_fpmult_rr_scheduler;

    localparam int N = 32;
    localparam int NR = 4;
    localparam int LIMIT = 300;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req_val;
    logic [3:0]    req_rdy;
    logic [255:0]  req_msg;
    logic [3:0]    resp_val;
    logic [3:0]    resp_rdy;
    logic [31:0]   resp_msg;
    logic          mult_recv_val;
    logic          mult_recv_rdy;
    logic [63:0]   mult_recv_msg;
    logic          mult_send_val;
    logic          mult_send_rdy;
    logic [31:0]   mult_send_msg;
    logic [1:0]    owner;

    int nvec = 0;
    int nerr = 0;
    int lat = 34;
    int m_prio = 0;
    logic [31:0] op_a [4];
    logic [31:0] op_b [4];

    always #5 clk = ~clk;

    fpmult_rr_scheduler #(
        .n(32),
        .d(16),
        .NREQ(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .mult_recv_val(mult_recv_val),
        .mult_recv_rdy(mult_recv_rdy),
        .mult_recv_msg(mult_recv_msg),
        .mult_send_val(mult_send_val),
        .mult_send_rdy(mult_send_rdy),
        .mult_send_msg(mult_send_msg),
        .owner        (owner)
    );

    function automatic logic [31:0] fx_mul(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[47:16];
    endfunction

    // Reference arbitration: first valid port scanning upward from the priority index.
    function automatic int exp_grant(input logic [3:0] rv, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (rv[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    // Stub multiplier: accepts when idle, presents the product after lat cycles.
    logic        s_busy;
    int          s_cnt;
    logic [31:0] s_prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_busy <= 1'b0;
            s_cnt  <= 0;
            s_prod <= '0;
        end else if (!s_busy && mult_recv_val) begin
            s_busy <= 1'b1;
            s_cnt  <= lat;
            s_prod <= fx_mul(mult_recv_msg[63:32], mult_recv_msg[31:0]);
        end else if (s_busy && s_cnt != 0) begin
            s_cnt <= s_cnt - 1;
        end else if (s_busy && mult_send_rdy) begin
            s_busy <= 1'b0;
        end
    end

    assign mult_recv_rdy = !s_busy;
    assign mult_send_val = s_busy && (s_cnt == 0);
    assign mult_send_msg = s_prod;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int p, input logic [31:0] a, input logic [31:0] b);
        op_a[p] = a;
        op_b[p] = b;
        req_msg[p*64 +: 64] = {a, b};
    endtask

    // Ends on the negedge before the accepting edge; t = cycles waited.
    task automatic wait_recv(output int t);
        t = 0;
        @(negedge clk);
        while (!(mult_recv_val && mult_recv_rdy) && t < LIMIT) begin
            step();
            @(negedge clk);
            t++;
        end
    endtask

    task automatic wait_resp(output int t);
        t = 0;
        @(negedge clk);
        while (resp_val == 4'b0 && t < LIMIT) begin
            step();
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_val = '0;
        resp_rdy = '0;
        req_msg = '0;
        step();
        step();
        @(negedge clk);
        nvec++; if (req_rdy !== 4'b0) begin nerr++;
            $display("FAIL reset_req_rdy got %b want 0000", req_rdy); end
        nvec++; if (resp_val !== 4'b0) begin nerr++;
            $display("FAIL reset_resp_val got %b want 0000", resp_val); end
        nvec++; if (mult_recv_val !== 1'b0) begin nerr++;
            $display("FAIL reset_recv_val got %b want 0", mult_recv_val); end
        nvec++; if (mult_send_rdy !== 1'b0) begin nerr++;
            $display("FAIL reset_send_rdy got %b want 0", mult_send_rdy); end
        nvec++; if (owner !== 2'd0) begin nerr++;
            $display("FAIL reset_owner got %0d want 0", owner); end
        step();
        reset = 1'b0;
        m_prio = 0;
        step();
    endtask

    task automatic test_round_robin();
        int t;
        lat = 3;
        for (int p = 0; p < NR; p++) set_ops(p, $urandom, $urandom);
        req_val = 4'hF;
        resp_rdy = 4'hF;
        for (int j = 0; j < 8; j++) begin
            wait_recv(t);
            if (j > 0) begin
                nvec++; if (t != 0) begin nerr++;
                    $display("FAIL rr_bubble job %0d got %0d extra idle cycles want 0", j, t); end
            end
            nvec++; if (req_rdy !== (4'b1 << (j % 4))) begin nerr++;
                $display("FAIL rr_grant job %0d got %b want port %0d", j, req_rdy, j % 4); end
            step();
            wait_resp(t);
            nvec++; if (resp_val !== (4'b1 << (j % 4)) ||
                        resp_msg !== fx_mul(op_a[j % 4], op_b[j % 4])) begin nerr++;
                $display("FAIL rr_resp job %0d got %b/%h want port %0d/%h", j, resp_val,
                         resp_msg, j % 4, fx_mul(op_a[j % 4], op_b[j % 4])); end
            step();
            m_prio = (j % 4 + 1) % NR;
        end
        req_val = '0;
        nvec++; if (owner !== 2'd3) begin nerr++;
            $display("FAIL rr_last_owner got %0d want 3", owner); end
        @(negedge clk);
        step();
    endtask

    task automatic test_single_port();
        int t;
        lat = 34;
        set_ops(2, 32'h0002_0000, 32'h0003_0000);
        req_val = 4'b0100;
        resp_rdy = 4'hF;
        wait_recv(t);
        nvec++; if (t >= LIMIT || req_rdy !== 4'b0100 ||
                    mult_recv_msg !== 64'h0002_0000_0003_0000) begin nerr++;
            $display("FAIL single_accept got rdy %b msg %h want 0100 %h", req_rdy,
                     mult_recv_msg, 64'h0002_0000_0003_0000); end
        step();
        req_val = '0;
        wait_resp(t);
        nvec++; if (t != 34) begin nerr++;
            $display("FAIL single_latency got %0d want 34", t); end
        nvec++; if (resp_val !== 4'b0100) begin nerr++;
            $display("FAIL single_resp_val got %b want 0100", resp_val); end
        nvec++; if (resp_msg !== 32'h0006_0000) begin nerr++;
            $display("FAIL single_resp_msg got %h want 00060000", resp_msg); end
        step();
        m_prio = 3;
    endtask

    task automatic test_wrap();
        int t;
        lat = 4;
        resp_rdy = 4'hF;
        set_ops(1, 32'h0001_8000, 32'h0002_0000);
        set_ops(3, 32'h0004_0000, 32'h0000_8000);
        // A port-1 job moves the priority to 2.
        req_val = 4'b0010;
        wait_recv(t);
        step();
        req_val = '0;
        wait_resp(t);
        step();
        m_prio = 2;
        req_val = 4'b1010;
        wait_recv(t);
        nvec++; if (req_rdy !== (4'b1 << exp_grant(4'b1010, m_prio))) begin nerr++;
            $display("FAIL wrap_first got %b want port 3", req_rdy); end
        step();
        req_val = 4'b0010;
        wait_resp(t);
        nvec++; if (owner !== 2'd3 || resp_msg !== fx_mul(op_a[3], op_b[3])) begin nerr++;
            $display("FAIL wrap_owner3 got %0d/%h want 3/%h", owner, resp_msg,
                     fx_mul(op_a[3], op_b[3])); end
        step();
        m_prio = 0;
        wait_recv(t);
        nvec++; if (req_rdy !== (4'b1 << exp_grant(4'b0010, m_prio)) || t != 0) begin nerr++;
            $display("FAIL wrap_second got %b after %0d want 0010 after 0", req_rdy, t); end
        step();
        req_val = '0;
        wait_resp(t);
        nvec++; if (resp_val !== 4'b0010) begin nerr++;
            $display("FAIL wrap_second_resp got %b want 0010", resp_val); end
        step();
        m_prio = 2;
    endtask

    task automatic test_owner_stall();
        int t;
        lat = 5;
        set_ops(0, 32'h0003_0000, 32'h0001_0000);
        set_ops(2, 32'h0000_4000, 32'h0008_0000);
        req_val = 4'b0001;
        resp_rdy = 4'b0;
        wait_recv(t);
        nvec++; if (req_rdy !== 4'b0001) begin nerr++;
            $display("FAIL stall_grant got %b want 0001", req_rdy); end
        step();
        req_val = 4'b0100;
        wait_resp(t);
        for (int i = 0; i < 10; i++) begin
            nvec++; if (mult_send_rdy !== 1'b0 || resp_val !== 4'b0001 || req_rdy !== 4'b0)
            begin nerr++;
                $display("FAIL stall_hold cyc %0d got srdy %b rval %b rrdy %b want 0 0001 0000",
                         i, mult_send_rdy, resp_val, req_rdy); end
            step();
            @(negedge clk);
        end
        resp_rdy = 4'b0001;
        #1;
        nvec++; if (mult_send_rdy !== 1'b1 || resp_msg !== fx_mul(op_a[0], op_b[0])) begin
            nerr++;
            $display("FAIL stall_release got %b/%h want 1/%h", mult_send_rdy, resp_msg,
                     fx_mul(op_a[0], op_b[0])); end
        step();
        m_prio = 1;
        @(negedge clk);
        nvec++; if (req_rdy !== 4'b0100 || mult_recv_val !== 1'b1) begin nerr++;
            $display("FAIL stall_next_grant got %b/%b want 0100/1", req_rdy, mult_recv_val); end
        step();
        req_val = '0;
        resp_rdy = 4'hF;
        wait_resp(t);
        step();
        m_prio = 3;
    endtask

    task automatic test_wait_request();
        int t;
        lat = 6;
        resp_rdy = 4'hF;
        set_ops(1, 32'h0002_0000, 32'h0002_0000);
        req_val = 4'b0001;
        wait_recv(t);
        nvec++; if (req_rdy !== 4'b0001) begin nerr++;
            $display("FAIL waitreq_grant got %b want 0001", req_rdy); end
        step();
        req_val = 4'b0010;
        t = 0;
        @(negedge clk);
        while (resp_val == 4'b0 && t < LIMIT) begin
            nvec++; if (req_rdy !== 4'b0 || mult_recv_val !== 1'b0) begin nerr++;
                $display("FAIL waitreq_blocked got %b/%b want 0000/0", req_rdy, mult_recv_val);
            end
            step();
            @(negedge clk);
            t++;
        end
        step();
        m_prio = 1;
        @(negedge clk);
        nvec++; if (req_rdy !== 4'b0010 || mult_recv_val !== 1'b1) begin nerr++;
            $display("FAIL waitreq_first_idle got %b/%b want 0010/1", req_rdy, mult_recv_val); end
        step();
        req_val = '0;
        wait_resp(t);
        step();
        m_prio = 2;
    endtask

    task automatic test_reset_mid_wait();
        int t;
        lat = 34;
        req_val = 4'b0001;
        wait_recv(t);
        step();
        req_val = '0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        @(negedge clk);
        nvec++; if (req_rdy !== 4'b0 || resp_val !== 4'b0 || mult_recv_val !== 1'b0 ||
                    mult_send_rdy !== 1'b0 || owner !== 2'd0) begin nerr++;
            $display("FAIL midwait_reset got %b %b %b %b %0d want all 0", req_rdy, resp_val,
                     mult_recv_val, mult_send_rdy, owner); end
        step();
        reset = 1'b0;
        m_prio = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            nvec++; if (resp_val !== 4'b0) begin nerr++;
                $display("FAIL midwait_no_resp cyc %0d got %b want 0000", i, resp_val); end
            step();
        end
        // Priority must be back at 0: ports 1 and 3 valid picks 1.
        set_ops(3, 32'h0001_0000, 32'h0001_0000);
        req_val = 4'b1010;
        lat = 2;
        wait_recv(t);
        nvec++; if (req_rdy !== (4'b1 << exp_grant(4'b1010, m_prio))) begin nerr++;
            $display("FAIL midwait_prio got %b want 0010", req_rdy); end
        step();
        req_val = '0;
        wait_resp(t);
        step();
        m_prio = 2;
    endtask

    task automatic test_random();
        int t;
        int g;
        int k;
        logic [3:0] rv;
        for (int j = 0; j < 40; j++) begin
            lat = $urandom_range(1, 6);
            rv = 4'($urandom_range(1, 15));
            for (int p = 0; p < NR; p++) set_ops(p, $urandom, $urandom);
            req_val = rv;
            resp_rdy = 4'b0;
            g = exp_grant(rv, m_prio);
            wait_recv(t);
            nvec++; if (t >= LIMIT || req_rdy !== (4'b1 << g) ||
                        mult_recv_msg !== {op_a[g], op_b[g]}) begin nerr++;
                $display("FAIL rand_grant job %0d got %b/%h want port %0d/%h", j, req_rdy,
                         mult_recv_msg, g, {op_a[g], op_b[g]}); end
            step();
            req_val = 4'($urandom);
            wait_resp(t);
            k = $urandom_range(0, 3);
            for (int s = 0; s < k; s++) begin
                step();
                @(negedge clk);
            end
            resp_rdy = 4'($urandom) | (4'b1 << g);
            #1;
            nvec++; if (t >= LIMIT || resp_val !== (4'b1 << g) || owner !== 2'(g) ||
                        resp_msg !== fx_mul(op_a[g], op_b[g]) || mult_send_rdy !== 1'b1)
            begin nerr++;
                $display("FAIL rand_resp job %0d got %b/%0d/%h/%b want port %0d/%h/1", j,
                         resp_val, owner, resp_msg, mult_send_rdy, g,
                         fx_mul(op_a[g], op_b[g])); end
            step();
            m_prio = (g + 1) % NR;
        end
        req_val = '0;
        resp_rdy = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_port();
        test_wrap();
        test_owner_stall();
        test_wait_request();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
